// File: rtl/spi_slave_if.sv
// Pin-level bundle between an SPI master and one slave endpoint, plus the
// local-side data/handshake signals of the slave.
interface spi_slave_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  SCLK;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;
  logic                  misoOe;
  logic [DATA_WIDTH-1:0] slaveDataToSend;
  logic [DATA_WIDTH-1:0] slaveDataReceived;
  logic                  rxValid;
  logic                  busy;

  modport slave (
    input  SCLK,
    input  CS,
    input  MOSI,
    input  slaveDataToSend,
    output MISO,
    output misoOe,
    output slaveDataReceived,
    output rxValid,
    output busy
  );

  modport master (
    output SCLK,
    output CS,
    output MOSI,
    output slaveDataToSend,
    input  MISO,
    input  misoOe,
    input  slaveDataReceived,
    input  rxValid,
    input  busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint, LSB-first, fully oversampled in the local clock domain.
// SCLK/CS/MOSI are synchronised and edge-detected; MOSI is sampled and MISO
// advanced on SCLK falling edges. A completed byte is published one cycle
// after the final falling edge is acted on, with a single-cycle rxValid.
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        reset,
  spi_slave_if.slave bus
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_received_q;
  logic                  rx_valid_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_fall, cs_fall, cs_rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Rising SCLK edges need no action (MOSI is in transition then), so only
  // the falling edge is decoded.
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;

  // Input synchronisers plus one delay stage on SCLK/CS for edge detection;
  // reset to bus idle levels so no spurious edge appears after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  // Frame state and shift datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state: CS edges frame the transfer; falling SCLK shifts one bit.
  // In idle only a CS fall is looked at, so a coincident SCLK fall is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StActive;
          tx_d    = bus.slaveDataToSend;
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (cs_rise) begin
          // Partial data is simply abandoned; only a completed byte publishes.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sclk_fall) begin
          rx_d[cnt_q] = mosi_s;
          if (cnt_q == LastBit) begin
            cnt_d  = '0;
            tx_d   = bus.slaveDataToSend;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            tx_d  = tx_q >> 1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Publish the assembled byte the cycle after the last bit lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_received_q <= '0;
      rx_valid_q      <= 1'b0;
    end else begin
      rx_valid_q <= done_q;
      if (done_q) begin
        data_received_q <= rx_q;
      end
    end
  end

  assign bus.MISO              = (state_q == StActive) & tx_q[0];
  assign bus.misoOe            = (state_q == StActive);
  assign bus.busy              = (state_q == StActive);
  assign bus.slaveDataReceived = data_received_q;
  assign bus.rxValid           = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed + random bench for spi_slave. The reference model is the SPI
// contract itself: each completed frame must deliver the MOSI byte once on
// rxValid, and MISO read at SCLK falls must spell the byte to send.
module tb_spi_slave;

  logic clk;
  logic reset;

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // rxValid monitor: pulses, high cycles and published bytes.
  int         pulses     = 0;
  int         hi_cycles  = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] rx_seen[$];

  always @(negedge clk) begin
    if (bus.rxValid === 1'b1) begin
      hi_cycles++;
      if (prev_valid !== 1'b1) begin
        pulses++;
        rx_seen.push_back(bus.slaveDataReceived);
      end
    end
    prev_valid = bus.rxValid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect exactly one published byte since the last call, equal to exp.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_count"}, 32'(rx_seen.size()), 32'd1);
    if (rx_seen.size() > 0) begin
      chk({tag, "_data"}, 32'(rx_seen[0]), 32'(exp));
      rx_seen.delete();
    end
  endtask

  // Place pin activity 1..4 ns after a clock edge so it never races the DUT.
  task automatic align();
    @(posedge clk);
    #($urandom_range(1, 4));
  endtask

  task automatic start_frame(input int half);
    align();
    bus.CS = 1'b0;
    #(2 * half);
  endtask

  task automatic end_frame();
    bus.CS = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Drive n bits LSB-first; MOSI changes just after each rise, MISO is read
  // at each fall. next_tx is applied right after the final fall.
  task automatic shift_bits(input logic [7:0] mosi, input int n, input int half,
                            input logic [7:0] next_tx, output logic [7:0] miso,
                            output logic oe_any);
    miso   = '0;
    oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.SCLK = 1'b1;
      bus.MOSI = mosi[i];
      oe_any   = oe_any | bus.misoOe;
      #half;
      bus.SCLK = 1'b0;
      miso[i]  = bus.MISO;
      oe_any   = oe_any | bus.misoOe;
      if (i == n - 1) bus.slaveDataToSend = next_tx;
      #half;
    end
  endtask

  logic [7:0] miso_bits;
  logic       oe_any;
  logic [7:0] tx_b, rx_b;
  int         p0;
  int         exp_pulses = 0;

  initial begin
    reset               = 1'b1;
    bus.SCLK            = 1'b0;
    bus.CS              = 1'b1;
    bus.MOSI            = 1'b0;
    bus.slaveDataToSend = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_oe", 32'(bus.misoOe), 32'd0);
    chk("rst_data", 32'(bus.slaveDataReceived), 32'd0);
    chk("rst_valid", 32'(bus.rxValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Single byte at 8x: A5 in, 3C out
    bus.slaveDataToSend = 8'h3C;
    start_frame(40);
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_oe", 32'(bus.misoOe), 32'd1);
    shift_bits(8'hA5, 8, 40, 8'h3C, miso_bits, oe_any);
    end_frame();
    exp_pulses++;
    chk("single_miso", 32'(miso_bits), 32'h3C);
    pop_chk("single_rx", 8'hA5);
    chk("single_idle_oe", 32'(bus.misoOe), 32'd0);

    // Back-to-back under one CS: 01 then FF in, 55 then AA out
    bus.slaveDataToSend = 8'h55;
    start_frame(40);
    shift_bits(8'h01, 8, 40, 8'hAA, miso_bits, oe_any);
    chk("b2b_miso0", 32'(miso_bits), 32'h55);
    chk("b2b_busy_mid", 32'(bus.busy), 32'd1);
    shift_bits(8'hFF, 8, 40, 8'hAA, miso_bits, oe_any);
    chk("b2b_miso1", 32'(miso_bits), 32'hAA);
    end_frame();
    exp_pulses += 2;
    chk("b2b_count", 32'(rx_seen.size()), 32'd2);
    if (rx_seen.size() == 2) begin
      chk("b2b_rx0", 32'(rx_seen[0]), 32'h01);
      chk("b2b_rx1", 32'(rx_seen[1]), 32'hFF);
    end
    rx_seen.delete();

    // Abort after 5 bits of 7E
    p0 = pulses;
    start_frame(40);
    shift_bits(8'h7E, 5, 40, 8'hAA, miso_bits, oe_any);
    bus.CS = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_oe", 32'(bus.misoOe), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pulses", 32'(pulses - p0), 32'd0);
    chk("abort_hold", 32'(bus.slaveDataReceived), 32'hFF);

    // Deselected: SCLK toggles with CS high
    p0 = pulses;
    align();
    shift_bits(8'h81, 8, 40, 8'hAA, miso_bits, oe_any);
    repeat (8) @(posedge clk);
    #1;
    chk("desel_miso", 32'(miso_bits), 32'h00);
    chk("desel_oe", 32'(oe_any), 32'd0);
    chk("desel_pulses", 32'(pulses - p0), 32'd0);

    // Reset mid-frame, then a clean 5A frame
    start_frame(40);
    shift_bits(8'h33, 3, 40, 8'hAA, miso_bits, oe_any);
    #3;
    reset    = 1'b1;
    bus.CS   = 1'b1;
    bus.SCLK = 1'b0;
    #1;
    chk("midrst_miso", 32'(bus.MISO), 32'd0);
    chk("midrst_oe", 32'(bus.misoOe), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_data", 32'(bus.slaveDataReceived), 32'd0);
    chk("midrst_valid", 32'(bus.rxValid), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    p0 = hi_cycles;
    start_frame(40);
    shift_bits(8'h5A, 8, 40, 8'hAA, miso_bits, oe_any);
    end_frame();
    exp_pulses++;
    chk("postrst_miso", 32'(miso_bits), 32'hAA);
    pop_chk("postrst_rx", 8'h5A);
    chk("postrst_width", 32'(hi_cycles - p0), 32'd1);

    // Minimum ratio: 4x SCLK, random phase, random bytes both ways
    for (int k = 0; k < 100; k++) begin
      tx_b = 8'($urandom_range(0, 255));
      rx_b = 8'($urandom_range(0, 255));
      bus.slaveDataToSend = tx_b;
      start_frame(20);
      shift_bits(rx_b, 8, 20, tx_b, miso_bits, oe_any);
      end_frame();
      exp_pulses++;
      chk("rand_miso", 32'(miso_bits), 32'(tx_b));
      pop_chk("rand_rx", rx_b);
    end

    chk("total_pulses", 32'(pulses), 32'(exp_pulses));
    chk("pulse_width", 32'(hi_cycles), 32'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
